// File: rtl/neuron_seq.sv
// neuron_seq: input sequencer and result capture for a single-neuron MAC stage.
// Buffers up to DEPTH packed 4-bit signed (input, weight) pairs, replays them
// into the MAC stage one per cycle, then captures the stage's ReLU output and
// holds it on a valid/ready result port until the consumer takes it.
module neuron_seq #(
    parameter int DEPTH = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [7:0]  i_in_data,
    input  logic        i_in_last,
    output logic [3:0]  o_mac_i,
    output logic [3:0]  o_mac_w,
    output logic        o_acc_clr,
    output logic        o_acc_en,
    input  logic [15:0] i_res_in,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [15:0] o_out_data,
    output logic [4:0]  o_out_count
);

    // Buffer address width; DEPTH is a power of two, so AW bits index every entry.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t         r_state;
    logic [4:0]     r_count;
    logic [AW-1:0]  r_rd_ptr;
    logic [7:0]     r_buf [DEPTH];
    logic           r_out_valid;
    logic [15:0]    r_out_data;
    logic [4:0]     r_out_count;

    logic           w_accept;
    logic [AW-1:0]  w_wr_addr;
    logic [7:0]     w_rd_entry;
    logic [4:0]     w_count_inc;
    logic           w_run_last;
    logic           w_in_run;

    // Ready is held low while reset is asserted so nothing is accepted until release.
    assign o_in_ready  = i_rst_n &&
                         ((r_state == S_IDLE) ||
                          ((r_state == S_FILL) && (r_count < DEPTH_C)));
    assign w_accept    = i_in_valid && o_in_ready;

    // In IDLE the count is always zero, but the first beat is pinned to entry 0 anyway.
    assign w_wr_addr   = (r_state == S_FILL) ? r_count[AW-1:0] : '0;
    assign w_count_inc = r_count + 5'd1;

    // Small buffer read asynchronously so the pair is on the MAC operands in the
    // same cycle rd_ptr points at it, including the first RUN cycle.
    assign w_rd_entry  = r_buf[r_rd_ptr];
    assign w_in_run    = (r_state == S_RUN);
    assign w_run_last  = (5'(r_rd_ptr) == (r_count - 5'd1));

    assign o_mac_i     = w_in_run ? w_rd_entry[3:0] : 4'd0;
    assign o_mac_w     = w_in_run ? w_rd_entry[7:4] : 4'd0;
    assign o_acc_en    = w_in_run;
    // Clear the accumulator in the same cycle the first pair of a vector is taken.
    assign o_acc_clr   = w_accept && (r_state == S_IDLE);

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_count = r_out_count;

    // Pair storage: write each accepted beat at its arrival position; no reset needed.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_buf[w_wr_addr] <= i_in_data;
        end
    end

    // Sequencer FSM: fill, replay, capture, then hold the result until taken.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_count     <= 5'd0;
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= 16'd0;
            r_out_count <= 5'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_count <= 5'd1;
                        if (i_in_last || (DEPTH == 1)) begin
                            r_state <= S_RUN;
                        end else begin
                            r_state <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (w_accept) begin
                        r_count <= w_count_inc;
                        // A full buffer forces the run even without in_last.
                        if (i_in_last || (w_count_inc == DEPTH_C)) begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_run_last) begin
                        r_rd_ptr <= '0;
                        r_state  <= S_CAPTURE;
                    end else begin
                        r_rd_ptr <= r_rd_ptr + AW'(1);
                    end
                end
                S_CAPTURE: begin
                    // Operands are zero here, so res_in is ReLU of the final total.
                    r_out_data  <= i_res_in;
                    r_out_count <= r_count;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_count     <= 5'd0;
                        r_rd_ptr    <= '0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_seq.sv
// tb_neuron_seq: directed and randomized vectors through neuron_seq with a
// simple MAC stage attached; results are compared against plain dot-product
// arithmetic over the pairs the bench sent.
module tb_neuron_seq;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'd0;
    logic        in_last = 1'b0;
    logic [3:0]  mac_i;
    logic [3:0]  mac_w;
    logic        acc_clr;
    logic        acc_en;
    logic [15:0] res_in;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [4:0]  out_count;

    always #5 clk = ~clk;

    neuron_seq #(.DEPTH(DEPTH)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_data   (in_data),
        .i_in_last   (in_last),
        .o_mac_i     (mac_i),
        .o_mac_w     (mac_w),
        .o_acc_clr   (acc_clr),
        .o_acc_en    (acc_en),
        .i_res_in    (res_in),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_out_count (out_count)
    );

    // Downstream MAC stage: 16-bit wrapping accumulator with ReLU output.
    // It has no reset of its own, so only acc_clr can remove stale totals.
    logic [15:0] mac_total = 16'd0;
    logic [15:0] mac_sum;
    logic [15:0] se_i;
    logic [15:0] se_w;
    always_comb begin
        se_i    = {{12{mac_i[3]}}, mac_i};
        se_w    = {{12{mac_w[3]}}, mac_w};
        mac_sum = mac_total + se_i * se_w;
        res_in  = mac_sum[15] ? 16'd0 : mac_sum;
    end
    always @(posedge clk) begin
        if (acc_clr)     mac_total <= 16'd0;
        else if (acc_en) mac_total <= mac_sum;
    end

    // Monitor: log every pair presented with acc_en, count clears and stray operands.
    logic [7:0] run_log[$];
    int clr_cnt = 0;
    int stray_mac = 0;
    always @(posedge clk) begin
        if (acc_en) run_log.push_back({mac_w, mac_i});
        if (acc_clr) clr_cnt++;
        if (!acc_en && (mac_i != 4'd0 || mac_w != 4'd0)) stray_mac++;
    end

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    logic [3:0] vi [DEPTH];
    logic [3:0] vw [DEPTH];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sx4(input logic [3:0] v);
        return v[3] ? int'(v) - 16 : int'(v);
    endfunction

    // Present one beat and hold it until accepted (bounded wait).
    task automatic send_beat(input logic [3:0] i, input logic [3:0] w, input logic last);
        int b;
        b = 0;
        in_valid = 1'b1;
        in_data  = {w, i};
        in_last  = last;
        while (!in_ready && b < 50) begin
            @(posedge clk); #1;
            b++;
        end
        check("beat_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'($urandom);
    endtask

    // Send vi/vw[0..n-1], wait for the result, check it, then release it.
    task automatic run_vector(input string name, input int n, input bit last_flag,
                              input bit gaps, input int hold);
        int sum;
        int lat;
        int run_base;
        int clr_base;
        logic [15:0] s16;
        logic [15:0] exp_data;
        sum = 0;
        for (int k = 0; k < n; k++) sum += sx4(vi[k]) * sx4(vw[k]);
        s16      = 16'(sum);
        exp_data = s16[15] ? 16'd0 : s16;
        run_base = run_log.size();
        clr_base = clr_cnt;
        check({name, "_idle_ready"}, in_ready, 1'b1);
        out_ready = (hold == 0);
        for (int k = 0; k < n; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk); #1;
                end
            end
            send_beat(vi[k], vw[k], last_flag && (k == n - 1));
        end
        check({name, "_ready_low_run"}, in_ready, 1'b0);
        // Counting the accepting edge, out_valid appears on edge N+2.
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, lat, n + 1);
        check({name, "_out_data"}, out_data, exp_data);
        check({name, "_out_count"}, out_count, 5'(n));
        check({name, "_run_len"}, run_log.size() - run_base, n);
        for (int k = 0; k < n; k++) begin
            if (run_base + k < run_log.size())
                check({name, "_run_pair"}, run_log[run_base + k], {vw[k], vi[k]});
        end
        check({name, "_clr_pulses"}, clr_cnt - clr_base, 1);
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                in_valid = 1'b1;
                in_last  = 1'b1;
                in_data  = 8'($urandom);
                @(posedge clk); #1;
                check({name, "_hold"}, {out_valid, in_ready, out_data, out_count},
                      {1'b1, 1'b0, exp_data, 5'(n)});
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check({name, "_release"}, {out_valid, in_ready}, 2'b01);
        out_ready = 1'b0;
        $display("vector %s: n=%0d out_data=0x%04h out_count=%0d latency=%0d",
                 name, n, out_data, out_count, lat);
    endtask

    initial begin
        int n;
        bit lf;
        // Reset state
        #12;
        check("reset_outputs", {acc_en, acc_clr, mac_i, mac_w, out_valid, out_data, out_count},
              {1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 16'd0, 5'd0});
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_ready", in_ready, 1'b1);

        // Two-pair vector: 3*2 + (-1)*4 = 2
        vi[0] = 4'h3; vw[0] = 4'h2;
        vi[1] = 4'hF; vw[1] = 4'h4;
        run_vector("two_pair", 2, 1'b1, 1'b0, 0);

        // Single negative pair: -8*7 = -56 -> ReLU 0
        vi[0] = 4'h8; vw[0] = 4'h7;
        run_vector("neg_single", 1, 1'b1, 1'b0, 0);

        // Full buffer without in_last: 8*49 = 392
        for (int k = 0; k < DEPTH; k++) begin vi[k] = 4'h7; vw[k] = 4'h7; end
        run_vector("forced_full", DEPTH, 1'b0, 1'b0, 0);

        // Backpressure: result held for 5 cycles
        for (int k = 0; k < 3; k++) begin vi[k] = 4'($urandom); vw[k] = 4'($urandom); end
        run_vector("backpressure", 3, 1'b1, 1'b0, 5);

        // Stalls: same vector with and without gaps
        for (int k = 0; k < 5; k++) begin vi[k] = 4'($urandom); vw[k] = 4'($urandom); end
        run_vector("no_gaps", 5, 1'b1, 1'b0, 0);
        run_vector("with_gaps", 5, 1'b1, 1'b1, 1);

        // Reset during the third RUN cycle of a 4-pair vector
        vi[0] = 4'h5; vw[0] = 4'h5;
        vi[1] = 4'h6; vw[1] = 4'h6;
        vi[2] = 4'h7; vw[2] = 4'h7;
        vi[3] = 4'h3; vw[3] = 4'h3;
        for (int k = 0; k < 4; k++) send_beat(vi[k], vw[k], k == 3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_third_run", {acc_en, mac_w, mac_i}, {1'b1, vw[2], vi[2]});
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_async_reset", {acc_en, acc_clr, mac_i, mac_w, out_valid, out_data, out_count},
              {1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 16'd0, 5'd0});
        @(posedge clk); #1;
        check("abort_reset_held", {acc_en, out_valid, out_count}, {1'b0, 1'b0, 5'd0});
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_ready_after", in_ready, 1'b1);
        vi[0] = 4'h2; vw[0] = 4'h2;
        run_vector("after_abort", 1, 1'b1, 1'b0, 0);

        // Randomized vectors
        for (int r = 0; r < 6; r++) begin
            n  = $urandom_range(1, DEPTH);
            lf = (n < DEPTH) ? 1'b1 : 1'($urandom);
            for (int k = 0; k < n; k++) begin vi[k] = 4'($urandom); vw[k] = 4'($urandom); end
            run_vector($sformatf("rand%0d", r), n, lf, 1'($urandom), $urandom_range(0, 3));
        end

        check("no_stray_operands", stray_mac, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
